risc_control_fsm: RTL and testbench
===================================

# risc_control_fsm

Multi-cycle control sequencer for the RISC core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the instruction-decoder load enable and issues memory handshakes. It produces per-cycle datapath control from the decoded `opcode`/`func` fields. It sits between the memory interface, the instruction decoder, the ALU and the register file, and is the only block that sequences them.

## Interface
- `RETIRE_W`, 16: width of retired-instruction counter.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  decoded opcode from the instruction decoder; valid from the DECODE cycle onward.
- `func`  in  6  decoded function field; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `alu_zero`  in  1  ALU result equals zero; sampled in EXEC.
- `state`  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- `ir_write`  out  1  decoder load enable (drives decoder `cnt`).
- `pc_inc`  out  1  PC += 4 pulse.
- `pc_jump`  out  1  PC <= jump target pulse.
- `pc_branch`  out  1  PC <= branch target pulse.
- `mem_req`  out  1  memory request active.
- `mem_we`  out  1  write request (valid with `mem_req`).
- `iord`  out  1  address select: 0 = PC (fetch), 1 = ALU result (data).
- `alu_en`  out  1  ALU operation active.
- `alu_op`  out  6  ALU function code.
- `reg_write`  out  1  register-file write enable.
- `wb_mem`  out  1  writeback source: 1 = memory data, 0 = ALU result.
- `halted`  out  1  core stopped.
- `illegal`  out  1  sticky: halted on an undefined opcode.
- `retired`  out  RETIRE_W  count of completed instructions, wraps.

## Operation
- Opcode classes:
  - 6'h00 R-type: ALU op = `func`.
  - 6'h10 LOAD.
  - 6'h11 STORE.
  - 6'h20 BEQ.
  - 6'h21 JMP.
  - 6'h3F HALT.
  - Any other value is illegal.
- In DECODE, the class is latched into an internal 3-bit register. EXEC, MEM and WB use the latched class, not the live `opcode`.
- Outputs are combinational from the registered state, the latched class, `func`, `mem_ready` and `alu_zero`. Any output not listed for a state is 0.
- IDLE: no outputs. Next state is FETCH unconditionally.
- FETCH:
  - `mem_req`=1, `iord`=0, `mem_we`=0.
  - Remains in FETCH while `mem_ready`=0.
  - On `mem_ready`=1, the same cycle asserts `ir_write`=1 and `pc_inc`=1, and the next state is DECODE.
- DECODE: no outputs except JMP's `pc_jump`.
  - R-type, LOAD, STORE, BEQ: next state EXEC.
  - JMP: `pc_jump`=1; next state FETCH; retires.
  - HALT: next state HALT; retires.
  - Illegal: next state HALT; `illegal` is set.
- EXEC: `alu_en`=1.
  - `alu_op` = `func` for R-type, 6'h20 (add) for LOAD/STORE, 6'h22 (sub) for BEQ.
  - Next state: R-type goes to WB; LOAD/STORE go to MEM; BEQ goes to FETCH, retires, and asserts `pc_branch` = `alu_zero`.
- MEM:
  - `mem_req`=1, `iord`=1, `mem_we`=1 only for STORE.
  - Waits on `mem_ready`.
  - When ready: LOAD goes to WB; STORE goes to FETCH and retires.
- WB: `reg_write`=1, `wb_mem` = (class == LOAD). Next state FETCH; retires.
- HALT: `halted`=1. Remains in HALT until `rst`. Inputs are ignored.
- Retire: `retired` increments by 1 on the clock edge of each retiring transition and wraps modulo 2^RETIRE_W. Illegal-opcode halts do not retire.
- No request is ever withdrawn: `mem_req` stays high until `mem_ready`, with a stable address select.

## Timing
- Reset:
  - `rst`=1 at a rising edge forces state=IDLE, `retired`=0, `illegal`=0 and the latched class to R-type. This applies from any state, including mid-FETCH or mid-MEM, where the pending request is abandoned.
  - Every output reads 0 in IDLE.
  - `rst` has priority over all transitions.
- The first FETCH is the cycle after `rst` deasserts.
- Minimum latency with `mem_ready` tied high:
  - JMP: 2 cycles.
  - BEQ: 3 cycles.
  - R-type and STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each stalled cycle in FETCH or MEM adds 1.
- `opcode`/`func` from the decoder become valid one edge after `ir_write`, i.e. in the DECODE cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- Single-cycle pulses: `ir_write`, `pc_inc`, `pc_jump`, `pc_branch`, `reg_write`. Never two PC pulses in one cycle.

## Test plan
- Reset release, `mem_ready`=1, instruction opcode 6'h00 func 6'h24 -> states 1,2,3,5,1; `alu_op`=6'h24 in EXEC; `reg_write`=1 for one cycle; `retired`=1.
- LOAD (6'h10), `mem_ready` low 2 cycles in FETCH and 3 in MEM -> FETCH 3 cycles, MEM 4 cycles, `iord`=1 and `mem_we`=0 in MEM, `wb_mem`=1 in WB; total 10 cycles.
- BEQ with `alu_zero`=1, then BEQ with `alu_zero`=0 -> `pc_branch` pulses only on the first; `alu_op`=6'h22 both times; `retired`=2.
- Opcode 6'h05 -> DECODE to HALT; `halted`=1, `illegal`=1, `retired` unchanged; remains in HALT for 20 cycles with `mem_ready` toggling.
- STORE stalled in MEM (`mem_we`=1), `rst` pulsed 1 cycle -> next state IDLE, `mem_req` drops, `retired`=0, `illegal`=0; FETCH resumes the following cycle.
- RETIRE_W=4, 17 consecutive JMPs -> `retired` reads 15 after 15 JMPs, 0 after 16, 1 after 17; `pc_jump` pulses every 2nd cycle.

Source files
------------

// File: rtl/risc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : risc_control_fsm
//  Purpose  : Multi-cycle control sequencer for the RISC core. Walks each
//             instruction through FETCH, DECODE, EXEC, MEM and WB, drives the
//             decoder load enable and memory handshakes, and produces the
//             per-cycle datapath controls.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             opcode_i, func_i      - decoded fields, valid from DECODE onward
//             mem_ready_i           - memory completes the current request
//             alu_zero_i            - ALU result is zero (used in EXEC)
//             state_o               - current state encoding
//             ir_write_o .. wb_mem_o - datapath / memory controls
//             halted_o, illegal_o   - stop status, sticky illegal flag
//             retired_o             - wrapping retired-instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module risc_control_fsm #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          func_i,
    input  logic                mem_ready_i,
    input  logic                alu_zero_i,
    output logic [2:0]          state_o,
    output logic                ir_write_o,
    output logic                pc_inc_o,
    output logic                pc_jump_o,
    output logic                pc_branch_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                iord_o,
    output logic                alu_en_o,
    output logic [5:0]          alu_op_o,
    output logic                reg_write_o,
    output logic                wb_mem_o,
    output logic                halted_o,
    output logic                illegal_o,
    output logic [RETIRE_W-1:0] retired_o
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;
    localparam logic [2:0] c_ST_HALT   = 3'd7;

    localparam logic [2:0] c_CLS_R     = 3'd0;
    localparam logic [2:0] c_CLS_LOAD  = 3'd1;
    localparam logic [2:0] c_CLS_STORE = 3'd2;
    localparam logic [2:0] c_CLS_BEQ   = 3'd3;
    localparam logic [2:0] c_CLS_JMP   = 3'd4;
    localparam logic [2:0] c_CLS_HALT  = 3'd5;
    localparam logic [2:0] c_CLS_ILL   = 3'd6;

    localparam logic [5:0] c_ALU_ADD   = 6'h20;
    localparam logic [5:0] c_ALU_SUB   = 6'h22;

    logic [2:0]          state_q, state_d;
    logic [2:0]          class_q, class_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic [2:0]          w_dec_class;
    logic                w_retire;
    logic                w_set_illegal;

    // Class of the live opcode; only meaningful in DECODE, where it is latched.
    always_comb begin
        w_dec_class = c_CLS_ILL;
        case (opcode_i)
            6'h00:   w_dec_class = c_CLS_R;
            6'h10:   w_dec_class = c_CLS_LOAD;
            6'h11:   w_dec_class = c_CLS_STORE;
            6'h20:   w_dec_class = c_CLS_BEQ;
            6'h21:   w_dec_class = c_CLS_JMP;
            6'h3F:   w_dec_class = c_CLS_HALT;
            default: w_dec_class = c_CLS_ILL;
        endcase
    end

    // State register plus the bookkeeping registers that move with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            class_q   <= c_CLS_R;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic. DECODE steers on the live opcode; later states use
    // the class latched at the end of DECODE.
    always_comb begin
        state_d       = state_q;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        case (state_q)
            c_ST_IDLE:  state_d = c_ST_FETCH;
            c_ST_FETCH: begin
                if (mem_ready_i) state_d = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                case (w_dec_class)
                    c_CLS_R, c_CLS_LOAD, c_CLS_STORE, c_CLS_BEQ: state_d = c_ST_EXEC;
                    c_CLS_JMP: begin
                        state_d  = c_ST_FETCH;
                        w_retire = 1'b1;
                    end
                    c_CLS_HALT: begin
                        state_d  = c_ST_HALT;
                        w_retire = 1'b1;
                    end
                    default: begin
                        state_d       = c_ST_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            c_ST_EXEC: begin
                case (class_q)
                    c_CLS_LOAD, c_CLS_STORE: state_d = c_ST_MEM;
                    c_CLS_BEQ: begin
                        state_d  = c_ST_FETCH;
                        w_retire = 1'b1;
                    end
                    default: state_d = c_ST_WB;
                endcase
            end
            c_ST_MEM: begin
                if (mem_ready_i) begin
                    if (class_q == c_CLS_STORE) begin
                        state_d  = c_ST_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        state_d = c_ST_WB;
                    end
                end
            end
            c_ST_WB: begin
                state_d  = c_ST_FETCH;
                w_retire = 1'b1;
            end
            c_ST_HALT: state_d = c_ST_HALT;
            // Encoding 6 is unreachable; recover through IDLE.
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        class_d   = (state_q == c_ST_DECODE) ? w_dec_class : class_q;
        illegal_d = illegal_q | w_set_illegal;
        retired_d = w_retire ? retired_q + RETIRE_W'(1) : retired_q;
    end

    // Output logic.
    always_comb begin
        ir_write_o  = 1'b0;
        pc_inc_o    = 1'b0;
        pc_jump_o   = 1'b0;
        pc_branch_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        iord_o      = 1'b0;
        alu_en_o    = 1'b0;
        alu_op_o    = 6'h00;
        reg_write_o = 1'b0;
        wb_mem_o    = 1'b0;
        halted_o    = 1'b0;
        case (state_q)
            c_ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_inc_o   = 1'b1;
                end
            end
            c_ST_DECODE: begin
                pc_jump_o = (w_dec_class == c_CLS_JMP);
            end
            c_ST_EXEC: begin
                alu_en_o = 1'b1;
                case (class_q)
                    c_CLS_R:                 alu_op_o = func_i;
                    c_CLS_LOAD, c_CLS_STORE: alu_op_o = c_ALU_ADD;
                    c_CLS_BEQ: begin
                        alu_op_o    = c_ALU_SUB;
                        pc_branch_o = alu_zero_i;
                    end
                    default:                 alu_op_o = 6'h00;
                endcase
            end
            c_ST_MEM: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = (class_q == c_CLS_STORE);
            end
            c_ST_WB: begin
                reg_write_o = 1'b1;
                wb_mem_o    = (class_q == c_CLS_LOAD);
            end
            c_ST_HALT: halted_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign retired_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_control_fsm
//  Purpose  : Directed self-checking bench for risc_control_fsm. Two DUT
//             copies share stimulus: default RETIRE_W and RETIRE_W=4 for the
//             counter wrap scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc_control_fsm;

    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [5:0] r_opcode = 6'h00;
    logic [5:0] r_func = 6'h00;
    logic       r_mem_ready = 1'b0;
    logic       r_alu_zero = 1'b0;

    logic [2:0]  w_state;
    logic        w_ir_write, w_pc_inc, w_pc_jump, w_pc_branch, w_mem_req, w_mem_we;
    logic        w_iord, w_alu_en, w_reg_write, w_wb_mem, w_halted, w_illegal;
    logic [5:0]  w_alu_op;
    logic [15:0] w_retired;

    logic [2:0]  w4_state;
    logic        w4_ir_write, w4_pc_inc, w4_pc_jump, w4_pc_branch, w4_mem_req, w4_mem_we;
    logic        w4_iord, w4_alu_en, w4_reg_write, w4_wb_mem, w4_halted, w4_illegal;
    logic [5:0]  w4_alu_op;
    logic [3:0]  w4_retired;

    int errors = 0;
    int checks = 0;

    // {state, ir_write, pc_inc, pc_jump, pc_branch, mem_req, mem_we, iord,
    //  alu_en, reg_write, wb_mem, halted, illegal}
    logic [14:0] w_sc;
    assign w_sc = {w_state, w_ir_write, w_pc_inc, w_pc_jump, w_pc_branch, w_mem_req,
                   w_mem_we, w_iord, w_alu_en, w_reg_write, w_wb_mem, w_halted, w_illegal};

    risc_control_fsm dut (
        .clk(clk), .rst(r_rst), .opcode_i(r_opcode), .func_i(r_func),
        .mem_ready_i(r_mem_ready), .alu_zero_i(r_alu_zero),
        .state_o(w_state), .ir_write_o(w_ir_write), .pc_inc_o(w_pc_inc),
        .pc_jump_o(w_pc_jump), .pc_branch_o(w_pc_branch), .mem_req_o(w_mem_req),
        .mem_we_o(w_mem_we), .iord_o(w_iord), .alu_en_o(w_alu_en), .alu_op_o(w_alu_op),
        .reg_write_o(w_reg_write), .wb_mem_o(w_wb_mem), .halted_o(w_halted),
        .illegal_o(w_illegal), .retired_o(w_retired)
    );

    risc_control_fsm #(.RETIRE_W(4)) dut4 (
        .clk(clk), .rst(r_rst), .opcode_i(r_opcode), .func_i(r_func),
        .mem_ready_i(r_mem_ready), .alu_zero_i(r_alu_zero),
        .state_o(w4_state), .ir_write_o(w4_ir_write), .pc_inc_o(w4_pc_inc),
        .pc_jump_o(w4_pc_jump), .pc_branch_o(w4_pc_branch), .mem_req_o(w4_mem_req),
        .mem_we_o(w4_mem_we), .iord_o(w4_iord), .alu_en_o(w4_alu_en), .alu_op_o(w4_alu_op),
        .reg_write_o(w4_reg_write), .wb_mem_o(w4_wb_mem), .halted_o(w4_halted),
        .illegal_o(w4_illegal), .retired_o(w4_retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        r_rst       = 1'b1;
        r_mem_ready = 1'b1;
        r_alu_zero  = 1'b0;
        tick();
        r_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        r_rst = 1'b1; r_mem_ready = 1'b1; r_alu_zero = 1'b1; r_opcode = 6'h3F;
        tick();
        checks++;
        if (w_sc !== 15'h0000 || w_retired !== 16'd0 || w_alu_op !== 6'h00) begin
            errors++;
            $display("FAIL reset_idle: sc=%h retired=%0d alu_op=%h, want sc=0000 retired=0 alu_op=00",
                     w_sc, w_retired, w_alu_op);
        end
        r_rst = 1'b0; #1;
        tick();
        checks++;
        if (w_state !== 3'd1) begin
            errors++;
            $display("FAIL reset_first_fetch: state=%0d want 1", w_state);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        r_opcode = 6'h00; r_func = 6'h24; #1;
        tick();
        checks++;
        if (w_sc !== {3'd1, 12'hC80}) begin
            errors++; $display("FAIL rtype_fetch: sc=%h want %h", w_sc, {3'd1, 12'hC80});
        end
        tick();
        checks++;
        if (w_sc !== {3'd2, 12'h000}) begin
            errors++; $display("FAIL rtype_decode: sc=%h want %h", w_sc, {3'd2, 12'h000});
        end
        tick();
        checks++;
        if (w_sc !== {3'd3, 12'h010} || w_alu_op !== 6'h24) begin
            errors++;
            $display("FAIL rtype_exec: sc=%h alu_op=%h want sc=%h alu_op=24", w_sc, w_alu_op, {3'd3, 12'h010});
        end
        tick();
        checks++;
        if (w_sc !== {3'd5, 12'h008}) begin
            errors++; $display("FAIL rtype_wb: sc=%h want %h", w_sc, {3'd5, 12'h008});
        end
        tick();
        checks++;
        if (w_state !== 3'd1 || w_reg_write !== 1'b0 || w_retired !== 16'd1) begin
            errors++;
            $display("FAIL rtype_retire: state=%0d reg_write=%b retired=%0d want 1 0 1",
                     w_state, w_reg_write, w_retired);
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        r_opcode = 6'h10; r_mem_ready = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (w_sc !== {3'd1, 12'h080}) begin
                errors++; $display("FAIL load_fetch_stall%0d: sc=%h want %h", i, w_sc, {3'd1, 12'h080});
            end
        end
        tick();
        r_mem_ready = 1'b1; #1;
        checks++;
        if (w_sc !== {3'd1, 12'hC80}) begin
            errors++; $display("FAIL load_fetch_ready: sc=%h want %h", w_sc, {3'd1, 12'hC80});
        end
        tick();
        checks++;
        if (w_state !== 3'd2) begin
            errors++; $display("FAIL load_decode: state=%0d want 2", w_state);
        end
        tick();
        r_mem_ready = 1'b0; #1;
        checks++;
        if (w_sc !== {3'd3, 12'h010} || w_alu_op !== 6'h20) begin
            errors++;
            $display("FAIL load_exec: sc=%h alu_op=%h want sc=%h alu_op=20", w_sc, w_alu_op, {3'd3, 12'h010});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                r_mem_ready = 1'b1; #1;
            end
            checks++;
            if (w_sc !== {3'd4, 12'h0A0}) begin
                errors++; $display("FAIL load_mem%0d: sc=%h want %h", i, w_sc, {3'd4, 12'h0A0});
            end
        end
        tick();
        checks++;
        if (w_sc !== {3'd5, 12'h00C}) begin
            errors++; $display("FAIL load_wb: sc=%h want %h", w_sc, {3'd5, 12'h00C});
        end
        tick();
        checks++;
        if (w_state !== 3'd1 || w_retired !== 16'd1) begin
            errors++; $display("FAIL load_retire: state=%0d retired=%0d want 1 1", w_state, w_retired);
        end
    endtask

    task automatic test_beq();
        do_reset();
        r_opcode = 6'h20; r_alu_zero = 1'b1; #1;
        tick(); tick();
        tick();
        checks++;
        if (w_sc !== {3'd3, 12'h110} || w_alu_op !== 6'h22) begin
            errors++;
            $display("FAIL beq_taken: sc=%h alu_op=%h want sc=%h alu_op=22", w_sc, w_alu_op, {3'd3, 12'h110});
        end
        tick();
        r_alu_zero = 1'b0; #1;
        checks++;
        if (w_sc !== {3'd1, 12'hC80} || w_retired !== 16'd1) begin
            errors++;
            $display("FAIL beq_refetch: sc=%h retired=%0d want sc=%h retired=1", w_sc, w_retired, {3'd1, 12'hC80});
        end
        tick();
        tick();
        checks++;
        if (w_sc !== {3'd3, 12'h010} || w_alu_op !== 6'h22) begin
            errors++;
            $display("FAIL beq_not_taken: sc=%h alu_op=%h want sc=%h alu_op=22", w_sc, w_alu_op, {3'd3, 12'h010});
        end
        tick();
        checks++;
        if (w_state !== 3'd1 || w_retired !== 16'd2) begin
            errors++; $display("FAIL beq_retire: state=%0d retired=%0d want 1 2", w_state, w_retired);
        end
    endtask

    task automatic test_halt_op();
        do_reset();
        r_opcode = 6'h3F; #1;
        tick(); tick();
        tick();
        checks++;
        if (w_sc !== {3'd7, 12'h002} || w_retired !== 16'd1) begin
            errors++;
            $display("FAIL halt_op: sc=%h retired=%0d want sc=%h retired=1", w_sc, w_retired, {3'd7, 12'h002});
        end
    endtask

    task automatic test_illegal();
        do_reset();
        r_opcode = 6'h05; #1;
        tick();
        tick();
        checks++;
        if (w_sc !== {3'd2, 12'h000}) begin
            errors++; $display("FAIL illegal_decode: sc=%h want %h", w_sc, {3'd2, 12'h000});
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            r_mem_ready = i[0];
            r_opcode    = 6'($urandom_range(0, 63));
            #1;
            checks++;
            if (w_sc !== {3'd7, 12'h003} || w_retired !== 16'd0) begin
                errors++;
                $display("FAIL illegal_halt%0d: sc=%h retired=%0d want sc=%h retired=0",
                         i, w_sc, w_retired, {3'd7, 12'h003});
            end
        end
        r_rst = 1'b1;
        tick();
        checks++;
        if (w_sc !== 15'h0000) begin
            errors++; $display("FAIL illegal_reset_clear: sc=%h want 0000", w_sc);
        end
        r_rst = 1'b0; #1;
    endtask

    task automatic test_store_reset();
        do_reset();
        r_opcode = 6'h21; #1;
        tick(); tick();
        tick();
        r_opcode = 6'h11; #1;
        tick(); tick();
        checks++;
        if (w_sc !== {3'd3, 12'h010} || w_alu_op !== 6'h20) begin
            errors++;
            $display("FAIL store_exec: sc=%h alu_op=%h want sc=%h alu_op=20", w_sc, w_alu_op, {3'd3, 12'h010});
        end
        r_mem_ready = 1'b0; #1;
        tick(); tick();
        checks++;
        if (w_sc !== {3'd4, 12'h0E0} || w_retired !== 16'd1) begin
            errors++;
            $display("FAIL store_mem_stall: sc=%h retired=%0d want sc=%h retired=1", w_sc, w_retired, {3'd4, 12'h0E0});
        end
        r_rst = 1'b1;
        tick();
        checks++;
        if (w_sc !== 15'h0000 || w_retired !== 16'd0) begin
            errors++;
            $display("FAIL store_reset_abort: sc=%h retired=%0d want sc=0000 retired=0", w_sc, w_retired);
        end
        r_rst = 1'b0; r_mem_ready = 1'b1; #1;
        tick();
        checks++;
        if (w_state !== 3'd1) begin
            errors++; $display("FAIL store_resume_fetch: state=%0d want 1", w_state);
        end
    endtask

    task automatic test_back_to_back_jmp();
        do_reset();
        r_opcode = 6'h21; #1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (w_sc !== {3'd1, 12'hC80} || w4_retired !== 4'(k - 1)) begin
                errors++;
                $display("FAIL jmp_fetch%0d: sc=%h retired4=%0d want sc=%h retired4=%0d",
                         k, w_sc, w4_retired, {3'd1, 12'hC80}, 4'(k - 1));
            end
            tick();
            checks++;
            if (w_sc !== {3'd2, 12'h200}) begin
                errors++; $display("FAIL jmp_decode%0d: sc=%h want %h", k, w_sc, {3'd2, 12'h200});
            end
        end
        tick();
        checks++;
        if (w4_retired !== 4'd1 || w_retired !== 16'd17) begin
            errors++;
            $display("FAIL jmp_wrap_final: retired4=%0d retired=%0d want 1 17", w4_retired, w_retired);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_beq();
        test_halt_op();
        test_illegal();
        test_store_reset();
        test_back_to_back_jmp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
